// File: rtl/demux_sched_pkg.sv
// demux_sched_pkg: shared constants and FSM state type for the demux round-robin scheduler.
package demux_sched_pkg;
    localparam int N_CH = 4;
    localparam int SEL_W = 2;
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
endpackage

// File: rtl/demux_rr_sched_pick.sv
// rr_pick4: combinational rotated-priority search starting one past the pointer.
module rr_pick4
    import demux_sched_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);
    logic [SEL_W-1:0] cand;
    // Walk from farthest to nearest so the nearest set bit after ptr is the last write.
    always_comb begin
        any = |req;
        idx = ptr;
        cand = ptr;
        for (int k = N_CH; k >= 1; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) idx = cand;
        end
    end
endmodule

// File: rtl/demux_rr_sched.sv
// demux_rr_sched: round-robin owner sequencing for the 1-to-4 demux with bounded dwell
// and a one-cycle break-before-make gap between owners.
module demux_rr_sched
    import demux_sched_pkg::*;
#(
    parameter int HOLD = 8,
    localparam int CNT_W = $clog2(HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  req,
    output logic [SEL_W-1:0] sel,
    output logic             en,
    output logic [N_CH-1:0]  grant,
    output logic             busy
);
    state_t state, state_nx;
    logic [SEL_W-1:0] owner, owner_nx, ptr, ptr_nx, pick_idx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic pick_any;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        ptr_nx = ptr;
        cnt_nx = cnt;
        case (state)
            IDLE: begin
                state_nx = pick_any ? GRANT : IDLE;
                owner_nx = pick_any ? pick_idx : owner;
                cnt_nx = '0;
            end
            GRANT: begin
                if (!req[owner] || cnt == CNT_W'(HOLD - 1)) begin
                    state_nx = GAP;
                    ptr_nx = owner;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            GAP: begin
                state_nx = pick_any ? GRANT : IDLE;
                owner_nx = pick_any ? pick_idx : owner;
                cnt_nx = '0;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from next-state so they switch on the same edge as the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= '0;
            ptr <= 2'b11;
            cnt <= '0;
            sel <= '0;
            en <= 1'b0;
            grant <= '0;
            busy <= 1'b0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            ptr <= ptr_nx;
            cnt <= cnt_nx;
            sel <= owner_nx;
            en <= state_nx == GRANT;
            grant <= state_nx == GRANT ? N_CH'(1) << owner_nx : '0;
            busy <= state_nx != IDLE;
        end
    end
endmodule
